// File: rtl/ptcalc_term_accum.sv
// Signed fit-term accumulator for the ptcalc datapath: sums a group of products,
// then rounds half-up, shifts and saturates into an unsigned pT word on a valid/ready register.
module ptcalc_term_accum #(
  parameter int PROD_W    = 31,
  parameter int MAX_TERMS = 8,
  parameter int ACC_W     = 35,
  parameter int SHIFT     = 12,
  parameter int OUT_W     = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  input  logic              prod_last,
  output logic              prod_ready,
  output logic [OUT_W-1:0]  pt_out,
  output logic              pt_ovf,
  output logic              pt_err,
  output logic              pt_valid,
  input  logic              pt_ready
);

  localparam int CNT_W = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TERMS - 1);
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(1) << (SHIFT - 1);

  logic signed [ACC_W-1:0] r_acc, w_acc_d;
  logic [CNT_W-1:0]        r_cnt, w_cnt_d;
  logic [OUT_W-1:0]        r_pt, w_pt_d;
  logic                    r_ovf, w_ovf_d;
  logic                    r_err, w_err_d;
  logic                    r_valid, w_valid_d;

  logic                    w_accept, w_at_max, w_close, w_force;
  logic signed [ACC_W-1:0] w_prod_ext, w_acc_next;
  logic signed [ACC_W:0]   w_sum, w_r;
  logic [OUT_W-1:0]        w_pt_sat;
  logic                    w_ovf_sat;

  assign prod_ready = !r_valid || pt_ready;
  assign w_accept   = prod_valid && prod_ready;
  assign w_at_max   = (r_cnt == CNT_MAX);
  assign w_close    = w_accept && (prod_last || w_at_max);
  assign w_force    = w_accept && !prod_last && w_at_max;

  assign w_prod_ext = {{(ACC_W-PROD_W){prod_in[PROD_W-1]}}, prod_in};
  assign w_acc_next = (r_cnt == '0) ? w_prod_ext : r_acc + w_prod_ext;

  // One guard bit above the accumulator so the rounding add can never wrap.
  assign w_sum = {w_acc_next[ACC_W-1], w_acc_next} + RND;
  assign w_r   = w_sum >>> SHIFT;

  always_comb begin
    w_pt_sat  = w_r[OUT_W-1:0];
    w_ovf_sat = 1'b0;
    if (w_r[ACC_W]) begin
      w_pt_sat  = '0;
      w_ovf_sat = 1'b1;
    end else if (|w_r[ACC_W-1:OUT_W]) begin
      w_pt_sat  = '1;
      w_ovf_sat = 1'b1;
    end
  end

  // Group state is carried by the term counter: cnt==0 is IDLE, otherwise ACCUM.
  always_comb begin
    w_acc_d   = r_acc;
    w_cnt_d   = r_cnt;
    w_pt_d    = r_pt;
    w_ovf_d   = r_ovf;
    w_err_d   = r_err;
    w_valid_d = r_valid;
    if (w_accept) begin
      if (w_close) begin
        w_acc_d = '0;
        w_cnt_d = '0;
      end else begin
        w_acc_d = w_acc_next;
        w_cnt_d = r_cnt + 1'b1;
      end
    end
    if (w_close) begin
      w_pt_d    = w_pt_sat;
      w_ovf_d   = w_ovf_sat;
      w_err_d   = w_force;
      w_valid_d = 1'b1;
    end else if (r_valid && pt_ready) begin
      w_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_pt    <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_acc   <= w_acc_d;
      r_cnt   <= w_cnt_d;
      r_pt    <= w_pt_d;
      r_ovf   <= w_ovf_d;
      r_err   <= w_err_d;
      r_valid <= w_valid_d;
    end
  end

  assign pt_out   = r_pt;
  assign pt_ovf   = r_ovf;
  assign pt_err   = r_err;
  assign pt_valid = r_valid;

endmodule

// File: tb/tb_ptcalc_term_accum.sv
// Bench for ptcalc_term_accum: directed vector table, hand-written corner sequences,
// then random valid/ready traffic scored against a sum-and-divide reference model.
module tb_ptcalc_term_accum;
  localparam int PROD_W = 31, MAX_TERMS = 8, ACC_W = 35, SHIFT = 12, OUT_W = 16;
  localparam longint MAXO = (longint'(1) << OUT_W) - 1;

  logic              ap_clk = 1'b0;
  logic              ap_rst;
  logic [PROD_W-1:0] prod_in;
  logic              prod_valid, prod_last, prod_ready;
  logic [OUT_W-1:0]  pt_out;
  logic              pt_ovf, pt_err, pt_valid, pt_ready;

  ptcalc_term_accum #(.PROD_W(PROD_W), .MAX_TERMS(MAX_TERMS), .ACC_W(ACC_W),
                      .SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_last(prod_last), .prod_ready(prod_ready), .pt_out(pt_out), .pt_ovf(pt_ovf),
    .pt_err(pt_err), .pt_valid(pt_valid), .pt_ready(pt_ready));

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]       n;
    logic [7:0][30:0] terms;
    logic             last;
    logic [15:0]      pt;
    logic             ovf;
    logic             err;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input int n, input longint a, input longint b, input longint c,
                              input bit last, input int pt, input bit ovf, input bit err);
    vec_t v;
    v.n = 4'(n);
    v.terms[0] = a[30:0];
    v.terms[1] = b[30:0];
    for (int i = 2; i < 8; i++) v.terms[i] = c[30:0];
    v.last = last; v.pt = 16'(pt); v.ovf = ovf; v.err = err;
    return v;
  endfunction

  // Reference: exact integer sum, floor division for round-half-up, then clamp.
  function automatic void ref_result(input longint s, output longint pt, output bit ovf);
    longint d, x, q;
    d = longint'(1) << SHIFT;
    x = s + (d / 2);
    if (x >= 0) q = x / d;
    else        q = -((-x + d - 1) / d);
    if (q < 0)         begin pt = 0;    ovf = 1'b1; end
    else if (q > MAXO) begin pt = MAXO; ovf = 1'b1; end
    else               begin pt = q;    ovf = 1'b0; end
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input longint v, input bit last);
    prod_valid = 1'b1; prod_in = v[30:0]; prod_last = last;
    @(posedge ap_clk); #1;
    prod_valid = 1'b0; prod_last = 1'b0;
  endtask

  task automatic idle();
    prod_valid = 1'b0;
    @(posedge ap_clk); #1;
  endtask

  task automatic chk_out(input string tag, input longint pt, input bit ovf, input bit err);
    chk({tag, ".valid"}, longint'(pt_valid), 1);
    chk({tag, ".pt"},    longint'(pt_out),   pt);
    chk({tag, ".ovf"},   longint'(pt_ovf),   longint'(ovf));
    chk({tag, ".err"},   longint'(pt_err),   longint'(err));
  endtask

  longint grp[$];
  longint m_pt, val, s;
  bit     m_ovf, m_err, m_pend, m_ready, closed, pv, pl, pr;
  logic [30:0] rnd31;

  initial begin
    ap_rst = 1'b1; prod_in = '0; prod_valid = 1'b0; prod_last = 1'b0; pt_ready = 1'b1;
    vecs[0] = mk(3, 4096, 8192, -2048, 1, 3, 0, 0);
    vecs[1] = mk(1, 2048, 0, 0, 1, 1, 0, 0);
    vecs[2] = mk(1, 2047, 0, 0, 1, 0, 0, 0);
    vecs[3] = mk(1, -5000, 0, 0, 1, 0, 1, 0);
    vecs[4] = mk(2, 1 << 29, 1 << 29, 0, 1, 65535, 1, 0);
    vecs[5] = mk(8, -(longint'(1) << 30), -(longint'(1) << 30), -(longint'(1) << 30), 1, 0, 1, 0);
    vecs[6] = mk(8, 4096, 4096, 4096, 0, 8, 0, 1);
    vecs[7] = mk(1, 65535 * 4096, 0, 0, 1, 65535, 0, 0);
    vecs[8] = mk(1, 65535 * 4096 + 2048, 0, 0, 1, 65535, 1, 0);

    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    chk("rst.pt", longint'(pt_out), 0);
    chk("rst.ovf", longint'(pt_ovf), 0);
    chk("rst.err", longint'(pt_err), 0);
    chk("rst.valid", longint'(pt_valid), 0);
    chk("rst.prod_ready", longint'(prod_ready), 1);

    foreach (vecs[k]) begin
      for (int i = 0; i < int'(vecs[k].n); i++)
        send(longint'($signed(vecs[k].terms[i])), (i == int'(vecs[k].n) - 1) ? vecs[k].last : 1'b0);
      chk_out($sformatf("vec%0d", k), longint'(vecs[k].pt), vecs[k].ovf, vecs[k].err);
      idle();
      chk($sformatf("vec%0d.one_cycle", k), longint'(pt_valid), 0);
    end

    // Forced close followed by a 9th term that must open a fresh group.
    for (int i = 0; i < 8; i++) send(4096, 1'b0);
    chk_out("force", 8, 0, 1);
    send(4096, 1'b1);
    chk_out("ninth", 1, 0, 0);
    idle();

    // Backpressure: pending result held while a term waits on prod_ready.
    pt_ready = 1'b0;
    send(8192, 1'b1);
    prod_valid = 1'b1; prod_in = 31'd4096; prod_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp.prod_ready", longint'(prod_ready), 0);
      chk("bp.pt", longint'(pt_out), 2);
      chk("bp.valid", longint'(pt_valid), 1);
      @(posedge ap_clk); #1;
    end
    pt_ready = 1'b1;
    #1 chk("bp.release", longint'(prod_ready), 1);
    @(posedge ap_clk); #1;
    prod_valid = 1'b0;
    chk("bp.drained", longint'(pt_valid), 0);
    send(4096, 1'b1);
    chk_out("bp.next", 2, 0, 0);

    // Back-to-back single-term groups: consume and reload on one edge.
    send(4096, 1'b1);
    chk_out("b2b.a", 1, 0, 0);
    send(12288, 1'b1);
    chk_out("b2b.b", 3, 0, 0);
    idle();

    // Reset mid-group discards the partial sum.
    for (int i = 0; i < 3; i++) send(4096, 1'b0);
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    chk("mid_rst.pt", longint'(pt_out), 0);
    chk("mid_rst.valid", longint'(pt_valid), 0);
    chk("mid_rst.prod_ready", longint'(prod_ready), 1);
    send(4096, 1'b0);
    send(4096, 1'b1);
    chk_out("post_rst", 2, 0, 0);
    idle();

    // Random traffic against the reference model.
    m_pend = 1'b0; grp.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pv = ($urandom_range(0, 3) != 0);
      pl = ($urandom_range(0, 4) == 0);
      pr = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 2))
        0: val = longint'($urandom_range(0, 20000)) - 10000;
        1: begin rnd31 = 31'($urandom); val = longint'($signed(rnd31)); end
        default: val = 65535 * 4096 + longint'($urandom_range(0, 16384)) - 8192;
      endcase
      prod_valid = pv; prod_in = val[30:0]; prod_last = pl; pt_ready = pr;
      #1;
      m_ready = !m_pend || pr;
      chk("rnd.prod_ready", longint'(prod_ready), longint'(m_ready));
      closed = 1'b0;
      if (pv && m_ready) begin
        grp.push_back(val);
        if (pl || grp.size() == MAX_TERMS) begin
          s = 0;
          foreach (grp[j]) s += grp[j];
          ref_result(s, m_pt, m_ovf);
          m_err = !pl;
          grp.delete();
          closed = 1'b1;
        end
      end
      if (closed) m_pend = 1'b1;
      else if (m_pend && pr) m_pend = 1'b0;
      @(posedge ap_clk); #1;
      chk("rnd.valid", longint'(pt_valid), longint'(m_pend));
      if (m_pend) begin
        chk("rnd.pt", longint'(pt_out), m_pt);
        chk("rnd.ovf", longint'(pt_ovf), longint'(m_ovf));
        chk("rnd.err", longint'(pt_err), longint'(m_err));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
